imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory's write port. The core is held in reset until a load session completes, then released to fetch from address 0.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write-port bundle for imem_loader.
// The master side feeds bytes and start requests; the loader is the slave.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, checksum
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, checksum
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them to
// consecutive instruction-memory words, and holds the core in reset until done.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_e;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q;
    logic [ADDR_W:0] target_q;
    logic [ADDR_W:0] word_idx_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     buf_q;
    logic [31:0]     checksum_q;
    logic [31:0]     imem_addr_q;
    logic [31:0]     imem_wdata_q;
    logic            in_ready_q;
    logic            imem_we_q;
    logic            cpu_reset_q;
    logic            busy_q;
    logic            done_q;

    logic [ADDR_W:0] target_d;
    logic [ADDR_W:0] word_idx_d;
    logic [31:0]     buf_d;
    logic            byte_accept;

    always_comb begin
        target_d    = (bus.word_count > CAPACITY) ? CAPACITY : bus.word_count;
        word_idx_d  = word_idx_q + IDX_ONE;
        buf_d       = {buf_q[23:0], bus.in_data};
        byte_accept = bus.in_valid && in_ready_q;
    end

    // NOTE: every register, outputs included, updates only here with <=; reset is
    // sampled on the clock edge, so there is no asynchronous path anywhere.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            target_q     <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            checksum_q   <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            imem_we_q <= 1'b0;
            unique case (state_q)
                IDLE, RUN: begin
                    if (bus.start) begin
                        target_q   <= target_d;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        checksum_q <= '0;
                        if (target_d == '0) begin
                            state_q     <= RUN;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state_q     <= RECV;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            cpu_reset_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_accept) begin
                        buf_q      <= buf_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            in_ready_q   <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= buf_d;
                            imem_addr_q  <= {{(30 - ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
                        end
                    end
                end
                WRITE: begin
                    // The word on imem_wdata commits at this edge; buf_q still holds it.
                    checksum_q <= checksum_q + buf_q;
                    word_idx_q <= word_idx_d;
                    byte_cnt_q <= '0;
                    if (word_idx_d == target_q) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.checksum   = checksum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader (ADDR_W=2): a count-based session model is
// compared against the DUT every cycle, plus literal checks on directed loads.
module tb_imem_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    imem_loader_if #(.ADDR_W(AW)) intf ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Writes observed on the memory port, in order.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    // Session model: tracks how many words/bytes of the session have happened.
    bit          m_valid;
    bit          m_loading;
    bit          m_writing;
    bit          m_run;
    bit          m_done;
    int          m_target;
    int          m_words;
    int          m_nbytes;
    logic [31:0] m_word;
    logic [31:0] m_sum;

    always @(negedge clk) begin
        if (m_valid) begin
            check("in_ready",  intf.in_ready,  32'(m_loading && !m_writing));
            check("busy",      intf.busy,      32'(m_loading));
            check("imem_we",   intf.imem_we,   32'(m_writing));
            check("cpu_reset", intf.cpu_reset, 32'(!m_run));
            check("done",      intf.done,      32'(m_done));
            check("checksum",  intf.checksum,  m_sum);
            if (m_writing) begin
                check("imem_addr",  intf.imem_addr,  32'(m_words * 4));
                check("imem_wdata", intf.imem_wdata, m_word);
            end
            if (intf.imem_we === 1'b1) begin
                wa_q.push_back(intf.imem_addr);
                wd_q.push_back(intf.imem_wdata);
            end
        end
        // Advance using the inputs the next rising edge will sample.
        if (reset) begin
            m_valid = 1; m_loading = 0; m_writing = 0; m_run = 0; m_done = 0;
            m_target = 0; m_words = 0; m_nbytes = 0; m_word = '0; m_sum = '0;
        end else if (m_valid) begin
            if (m_loading) begin
                m_done = 0;
                if (m_writing) begin
                    m_sum     = m_sum + m_word;
                    m_words   = m_words + 1;
                    m_writing = 0;
                    m_nbytes  = 0;
                    if (m_words == m_target) begin
                        m_loading = 0;
                        m_run     = 1;
                        m_done    = 1;
                    end
                end else if (intf.in_valid) begin
                    m_word   = {m_word[23:0], intf.in_data};
                    m_nbytes = m_nbytes + 1;
                    if (m_nbytes == 4) m_writing = 1;
                end
            end else begin
                m_done = 0;
                if (intf.start) begin
                    m_target = (int'(intf.word_count) > CAP) ? CAP : int'(intf.word_count);
                    m_words  = 0;
                    m_nbytes = 0;
                    m_sum    = '0;
                    if (m_target == 0) begin
                        m_run  = 1;
                        m_done = 1;
                    end else begin
                        m_run     = 0;
                        m_loading = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start(input int wc);
        intf.start      = 1'b1;
        intf.word_count = (AW + 1)'(wc);
        tick();
        intf.start = 1'b0;
        if (wc == 0) begin
            check("zero_done",   intf.done,      32'd1);
            check("zero_cpurst", intf.cpu_reset, 32'd0);
        end else begin
            check("start_ready",  intf.in_ready,  32'd1);
            check("start_cpurst", intf.cpu_reset, 32'd1);
        end
    endtask

    // Streams bytes; gappy randomizes in_valid, noisy toggles start/word_count meanwhile.
    task automatic send(input logic [7:0] bytes[$], input bit gappy, input bit noisy);
        foreach (bytes[k]) begin
            bit taken = 0;
            for (int n = 0; n < 200 && !taken; n++) begin
                logic rdy;
                intf.in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
                intf.in_data  = intf.in_valid ? bytes[k] : 8'($urandom);
                if (noisy) begin
                    intf.start      = 1'($urandom_range(0, 1));
                    intf.word_count = (AW + 1)'($urandom);
                end
                rdy = intf.in_ready;
                tick();
                if (intf.in_valid && rdy === 1'b1) taken = 1;
            end
            if (!taken) check("byte_timeout", 32'd0, 32'd1);
        end
        intf.in_valid = 1'b0;
        intf.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (intf.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", intf.done, 32'd1);
    endtask

    // Scoreboard of a whole session from the raw byte list.
    task automatic check_session(input logic [7:0] bytes[$], input int nwords);
        logic [31:0] sum = '0;
        check("write_count", 32'(wa_q.size()), 32'(nwords));
        for (int i = 0; i < nwords && i < wa_q.size(); i++) begin
            logic [31:0] w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            sum = sum + w;
            check("sb_addr", wa_q[i], 32'(i * 4));
            check("sb_data", wd_q[i], w);
        end
        check("sb_checksum", intf.checksum, sum);
    endtask

    initial begin
        logic [7:0] bq[$];
        checks = 0;
        errors = 0;
        reset = 1'b1;
        intf.start      = 1'b1;
        intf.word_count = '0;
        intf.in_valid   = 1'b1;
        intf.in_data    = 8'h5A;

        // Reset with start and in_valid held high
        tick();
        tick();
        check("rst_cpurst",  intf.cpu_reset, 32'd1);
        check("rst_ready",   intf.in_ready,  32'd0);
        check("rst_we",      intf.imem_we,   32'd0);
        check("rst_busy",    intf.busy,      32'd0);
        check("rst_done",    intf.done,      32'd0);
        check("rst_sum",     intf.checksum,  32'd0);
        reset = 1'b0;
        intf.start    = 1'b0;
        intf.in_valid = 1'b0;
        tick();
        check("post_rst_cpurst", intf.cpu_reset, 32'd1);
        check("post_rst_busy",   intf.busy,      32'd0);
        check("post_rst_ready",  intf.in_ready,  32'd0);

        // Basic two-word load
        clear_log();
        pulse_start(2);
        bq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        send(bq, 0, 0);
        wait_done(50);
        check("basic_n",     32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("basic_a0", wa_q[0], 32'h0);
            check("basic_d0", wd_q[0], 32'h2008_0005);
            check("basic_a1", wa_q[1], 32'h4);
            check("basic_d1", wd_q[1], 32'h0000_000C);
        end
        check("basic_sum",    intf.checksum,  32'h2008_0011);
        check("basic_cpurst", intf.cpu_reset, 32'd0);
        tick();
        check("basic_done_1cyc", intf.done,      32'd0);
        check("basic_run_hold",  intf.cpu_reset, 32'd0);
        check("basic_sum_hold",  intf.checksum,  32'h2008_0011);

        // Zero count from RUN
        clear_log();
        pulse_start(0);
        repeat (3) tick();
        check("zero_writes", 32'(wa_q.size()), 32'd0);
        check("zero_sum",    intf.checksum,    32'd0);

        // Clamp: 7 words requested on a 4-word memory, gapped stream
        clear_log();
        pulse_start(7);
        bq.delete();
        repeat (16) bq.push_back(8'($urandom));
        send(bq, 1, 0);
        wait_done(100);
        check("clamp_n", 32'(wa_q.size()), 32'd4);
        if (wa_q.size() == 4) begin
            check("clamp_a0", wa_q[0], 32'h0);
            check("clamp_a1", wa_q[1], 32'h4);
            check("clamp_a2", wa_q[2], 32'h8);
            check("clamp_a3", wa_q[3], 32'hC);
        end
        check_session(bq, 4);

        // Reset mid-load after two bytes, then a clean one-word load
        pulse_start(2);
        bq = '{8'h11, 8'h22};
        send(bq, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy",   intf.busy,      32'd0);
        check("midrst_cpurst", intf.cpu_reset, 32'd1);
        check("midrst_sum",    intf.checksum,  32'd0);
        clear_log();
        pulse_start(1);
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(bq, 1, 0);
        wait_done(50);
        check("midrst_n", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("midrst_a", wa_q[0], 32'h0);
            check("midrst_d", wd_q[0], 32'hAABB_CCDD);
        end
        check("midrst_chk", intf.checksum, 32'hAABB_CCDD);

        // Reload from RUN with start noise during RECV
        clear_log();
        pulse_start(1);
        bq.delete();
        repeat (4) bq.push_back(8'($urandom));
        send(bq, 1, 1);
        wait_done(50);
        check_session(bq, 1);

        // Random sessions
        for (int s = 0; s < 10; s++) begin
            int wc = $urandom_range(0, 7);
            int nw = (wc > CAP) ? CAP : wc;
            clear_log();
            pulse_start(wc);
            bq.delete();
            repeat (4 * nw) bq.push_back(8'($urandom));
            send(bq, 1, s[0]);
            wait_done(200);
            check_session(bq, nw);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
